// File: rtl/disk_track_sequencer.sv
// Sequences SD sector transfers for a NIB track buffer: writes back a dirty track,
// then loads the newly selected one, SECTORS sectors per track.
module disk_track_sequencer #(
  parameter int SECTORS = 13,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               track_dirty,
  input  logic               sd_ack,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy,
  output logic               dirty_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_SEC  = 4'(SECTORS - 1);
  localparam logic [31:0] SECTORS_W = 32'(SECTORS);

  // First LBA of a track; the track number is zero-extended before the multiply.
  function automatic logic [31:0] track_base(input logic [TRACK_W-1:0] t);
    logic [31:0] t_ext;
    t_ext = 32'(t);
    return t_ext * SECTORS_W;
  endfunction

  state_t             state_r, state_nx_s;
  logic [TRACK_W-1:0] cur_track_r, cur_track_nx_s;
  logic [TRACK_W-1:0] tgt_track_r, tgt_track_nx_s;
  logic               mount_pend_r, mount_pend_nx_s;
  logic               ack_d_r;
  logic [31:0]        lba_r, lba_nx_s;
  logic [3:0]         sec_r, sec_nx_s;
  logic               rd_r, rd_nx_s;
  logic               wr_r, wr_nx_s;
  logic               wait_r, wait_nx_s;
  logic               clr_r, clr_nx_s;
  logic               busy_r;
  logic               ack_rise_s;
  logic               ack_fall_s;

  assign ack_rise_s = sd_ack & ~ack_d_r;
  assign ack_fall_s = ~sd_ack & ack_d_r;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_nx_s      = state_r;
    cur_track_nx_s  = cur_track_r;
    tgt_track_nx_s  = tgt_track_r;
    mount_pend_nx_s = mount_pend_r | img_mounted;
    lba_nx_s        = lba_r;
    sec_nx_s        = sec_r;
    rd_nx_s         = rd_r;
    wr_nx_s         = wr_r;
    wait_nx_s       = wait_r;
    clr_nx_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A mount outranks a track change and never flushes the old buffer.
        if (mount_pend_r || img_mounted) begin
          mount_pend_nx_s = 1'b0;
          cur_track_nx_s  = track;
          tgt_track_nx_s  = track;
          clr_nx_s        = 1'b1;
          if (img_present) begin
            lba_nx_s   = track_base(track);
            sec_nx_s   = 4'd0;
            rd_nx_s    = 1'b1;
            wr_nx_s    = 1'b0;
            wait_nx_s  = 1'b1;
            state_nx_s = ST_LOAD;
          end else begin
            rd_nx_s   = 1'b0;
            wr_nx_s   = 1'b0;
            wait_nx_s = 1'b0;
          end
        end else if (track != cur_track_r) begin
          if (img_present) begin
            tgt_track_nx_s = track;
            sec_nx_s       = 4'd0;
            wait_nx_s      = 1'b1;
            if (track_dirty) begin
              lba_nx_s   = track_base(cur_track_r);
              wr_nx_s    = 1'b1;
              rd_nx_s    = 1'b0;
              state_nx_s = ST_FLUSH;
            end else begin
              cur_track_nx_s = track;
              lba_nx_s       = track_base(track);
              rd_nx_s        = 1'b1;
              wr_nx_s        = 1'b0;
              state_nx_s     = ST_LOAD;
            end
          end else begin
            cur_track_nx_s = track;
          end
        end else begin
          rd_nx_s   = 1'b0;
          wr_nx_s   = 1'b0;
          wait_nx_s = 1'b0;
        end
      end
      ST_FLUSH, ST_LOAD: begin
        if (ack_rise_s) begin
          lba_nx_s = lba_r + 32'd1;
          if (sec_r == LAST_SEC) begin
            rd_nx_s = 1'b0;
            wr_nx_s = 1'b0;
          end else begin
            rd_nx_s = rd_r;
          end
        end else begin
          lba_nx_s = lba_r;
        end
        if (ack_fall_s) begin
          sec_nx_s = sec_r + 4'd1;
          if (sec_r == LAST_SEC) begin
            // End of flush chains straight into the load of the target track.
            if (state_r == ST_FLUSH) begin
              clr_nx_s       = 1'b1;
              cur_track_nx_s = tgt_track_r;
              lba_nx_s       = track_base(tgt_track_r);
              sec_nx_s       = 4'd0;
              rd_nx_s        = 1'b1;
              wr_nx_s        = 1'b0;
              state_nx_s     = ST_LOAD;
            end else begin
              rd_nx_s    = 1'b0;
              wr_nx_s    = 1'b0;
              wait_nx_s  = 1'b0;
              state_nx_s = ST_IDLE;
            end
          end else begin
            state_nx_s = state_r;
          end
        end else begin
          sec_nx_s = sec_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        rd_nx_s    = 1'b0;
        wr_nx_s    = 1'b0;
        wait_nx_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cur_track_r  <= '0;
      tgt_track_r  <= '0;
      mount_pend_r <= 1'b0;
      ack_d_r      <= 1'b0;
      lba_r        <= 32'd0;
      sec_r        <= 4'd0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      wait_r       <= 1'b0;
      clr_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cur_track_r  <= cur_track_nx_s;
      tgt_track_r  <= tgt_track_nx_s;
      mount_pend_r <= mount_pend_nx_s;
      ack_d_r      <= sd_ack;
      lba_r        <= lba_nx_s;
      sec_r        <= sec_nx_s;
      rd_r         <= rd_nx_s;
      wr_r         <= wr_nx_s;
      wait_r       <= wait_nx_s;
      clr_r        <= clr_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
    end
  end

  assign sd_lba    = lba_r;
  assign sd_rd     = rd_r;
  assign sd_wr     = wr_r;
  assign track_sec = sec_r;
  assign cpu_wait  = wait_r;
  assign busy      = busy_r;
  assign dirty_clr = clr_r;

endmodule

// File: tb/tb_disk_track_sequencer.sv
// Self-checking bench for disk_track_sequencer: directed scenarios plus randomized
// track/mount traffic compared against a transfer-list model of the drive.
module tb_disk_track_sequencer;

  localparam int SECTORS = 13;
  localparam int TRACK_W = 6;

  typedef struct {
    logic        wr;
    logic [31:0] base;
  } xfer_t;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [TRACK_W-1:0] track;
  logic               img_mounted;
  logic               img_present;
  logic               track_dirty;
  logic               sd_ack;
  logic [31:0]        sd_lba;
  logic               sd_rd;
  logic               sd_wr;
  logic [3:0]         track_sec;
  logic               cpu_wait;
  logic               busy;
  logic               dirty_clr;

  int checks = 0;
  int errors = 0;
  int model_cur = 0;

  disk_track_sequencer #(.SECTORS(SECTORS), .TRACK_W(TRACK_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_present(img_present),
    .track_dirty(track_dirty), .sd_ack(sd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .track_sec(track_sec),
    .cpu_wait(cpu_wait), .busy(busy), .dirty_clr(dirty_clr)
  );

  always #5 clk_sys = ~clk_sys;

  // Read and write requests must never overlap.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (sd_rd === 1'b1 && sd_wr === 1'b1) begin
        errors++;
        $display("FAIL rd_wr_exclusive rd=%b wr=%b required not both high", sd_rd, sd_wr);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Acts as the SD host for n_sec sectors of one request, checking each sector.
  task automatic run_transfer(input logic is_wr, input logic [31:0] base, input int n_sec);
    for (int i = 0; i < n_sec; i++) begin
      checks++;
      if (sd_rd !== ~is_wr || sd_wr !== is_wr) begin
        errors++;
        $display("FAIL xfer_req sec %0d rd=%b wr=%b required rd=%b wr=%b", i, sd_rd, sd_wr, ~is_wr, is_wr);
      end
      checks++;
      if (sd_lba !== base + 32'(i)) begin
        errors++;
        $display("FAIL xfer_lba sec %0d got %0d required %0d", i, sd_lba, base + 32'(i));
      end
      checks++;
      if (track_sec !== 4'(i)) begin
        errors++;
        $display("FAIL xfer_sec got %0d required %0d", track_sec, i);
      end
      checks++;
      if (cpu_wait !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL xfer_wait cpu_wait=%b busy=%b required 1 1", cpu_wait, busy);
      end
      sd_ack = 1'b1;
      tick();
      tick();
      if (i == SECTORS - 1) begin
        checks++;
        if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
          errors++;
          $display("FAIL xfer_drop rd=%b wr=%b required 0 0", sd_rd, sd_wr);
        end
      end
      sd_ack = 1'b0;
      tick();
    end
  endtask

  task automatic mount_pulse(input logic [TRACK_W-1:0] t, input logic pres);
    track       = t;
    img_present = pres;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; track = '0; img_mounted = 1'b0; img_present = 1'b0;
    track_dirty = 1'b0; sd_ack = 1'b0;
    tick();
    tick();
    checks++;
    if ({sd_lba, track_sec, sd_rd, sd_wr, cpu_wait, busy, dirty_clr} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs lba=%0d sec=%0d rd=%b wr=%b wait=%b busy=%b clr=%b required all 0",
               sd_lba, track_sec, sd_rd, sd_wr, cpu_wait, busy, dirty_clr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_mount_load();
    mount_pulse(6'd5, 1'b1);
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd65 || cpu_wait !== 1'b1 || dirty_clr !== 1'b1) begin
      errors++;
      $display("FAIL mount_req rd=%b lba=%0d wait=%b clr=%b required 1 65 1 1", sd_rd, sd_lba, cpu_wait, dirty_clr);
    end
    run_transfer(1'b0, 32'd65, SECTORS);
    checks++;
    if (sd_lba !== 32'd78 || track_sec !== 4'd13 || cpu_wait !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mount_done lba=%0d sec=%0d wait=%b busy=%b required 78 13 0 0", sd_lba, track_sec, cpu_wait, busy);
    end
    model_cur = 5;
  endtask

  task automatic test_flush_and_change_during_load();
    track = 6'd6;
    track_dirty = 1'b1;
    tick();
    run_transfer(1'b1, 32'd65, SECTORS);
    checks++;
    if (dirty_clr !== 1'b1 || sd_rd !== 1'b1 || sd_lba !== 32'd78 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL flush_to_load clr=%b rd=%b lba=%0d wait=%b required 1 1 78 1", dirty_clr, sd_rd, sd_lba, cpu_wait);
    end
    track_dirty = 1'b0;
    track = 6'd7;
    run_transfer(1'b0, 32'd78, SECTORS);
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_lba !== 32'd91) begin
      errors++;
      $display("FAIL load6_done busy=%b rd=%b lba=%0d required 0 0 91", busy, sd_rd, sd_lba);
    end
    tick();
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd91 || busy !== 1'b1) begin
      errors++;
      $display("FAIL newest_track rd=%b lba=%0d busy=%b required 1 91 1", sd_rd, sd_lba, busy);
    end
    run_transfer(1'b0, 32'd91, SECTORS);
    model_cur = 7;
  endtask

  task automatic test_no_image();
    img_present = 1'b0;
    track = 6'd0;
    tick();
    track = 6'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_image_idle rd=%b wr=%b busy=%b required 0 0 0", sd_rd, sd_wr, busy);
      end
    end
    img_present = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sd_rd !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cur_track_3 rd=%b busy=%b required 0 0", sd_rd, busy);
      end
    end
    mount_pulse(6'd3, 1'b1);
    run_transfer(1'b0, 32'd39, SECTORS);
    model_cur = 3;
  endtask

  task automatic test_random();
    xfer_t exp_q[$];
    xfer_t x;
    int kind;
    int nt;
    logic pres;
    logic dirty;
    for (int it = 0; it < 24; it++) begin
      kind  = int'($urandom_range(0, 3));
      nt    = int'($urandom_range(0, 7));
      pres  = ($urandom_range(0, 3) != 0);
      dirty = 1'($urandom_range(0, 1));
      exp_q.delete();
      if (kind == 0) begin
        model_cur = nt;
        if (pres) exp_q.push_back('{wr: 1'b0, base: 32'(nt * SECTORS)});
      end else if (nt != model_cur) begin
        if (pres) begin
          if (dirty) exp_q.push_back('{wr: 1'b1, base: 32'(model_cur * SECTORS)});
          exp_q.push_back('{wr: 1'b0, base: 32'(nt * SECTORS)});
        end
        model_cur = nt;
      end
      track       = 6'(nt);
      img_present = pres;
      track_dirty = dirty;
      img_mounted = (kind == 0);
      tick();
      img_mounted = 1'b0;
      track_dirty = 1'b0;
      if (kind == 0) begin
        checks++;
        if (dirty_clr !== 1'b1) begin
          errors++;
          $display("FAIL rand_mount_clr it %0d got %b required 1", it, dirty_clr);
        end
      end
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        run_transfer(x.wr, x.base, SECTORS);
        if (x.wr) begin
          checks++;
          if (dirty_clr !== 1'b1) begin
            errors++;
            $display("FAIL rand_flush_clr it %0d got %b required 1", it, dirty_clr);
          end
        end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle it %0d busy=%b rd=%b wr=%b required 0 0 0", it, busy, sd_rd, sd_wr);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    mount_pulse(6'd0, 1'b1);
    run_transfer(1'b0, 32'd0, 4);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sd_lba, track_sec, sd_rd, sd_wr, cpu_wait, busy, dirty_clr} !== 41'd0) begin
      errors++;
      $display("FAIL async_abort lba=%0d sec=%0d rd=%b wr=%b wait=%b busy=%b required all 0",
               sd_lba, track_sec, sd_rd, sd_wr, cpu_wait, busy);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet rd=%b wr=%b busy=%b required 0 0 0", sd_rd, sd_wr, busy);
      end
    end
    mount_pulse(6'd0, 1'b1);
    run_transfer(1'b0, 32'd0, SECTORS);
    checks++;
    if (busy !== 1'b0 || sd_lba !== 32'(SECTORS)) begin
      errors++;
      $display("FAIL post_reset_load busy=%b lba=%0d required 0 %0d", busy, sd_lba, SECTORS);
    end
  endtask

  initial begin
    test_reset();
    test_mount_load();
    test_flush_and_change_during_load();
    test_no_image();
    test_random();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
